dm_cache_ctrl: RTL
==================

// Module: dm_cache_ctrl
// PURPOSE
// - Parametrised direct-mapped cache: valid, tag and data arrays with a lookup/fill/write-through controller.
// - Sits between the CPU load/store port and the memory port; serves read hits locally and fills lines on read misses.
// - Adds invalidate-all flush and saturating hit/miss counters.
// PARAMETERS
// - ADDR_W  29  word address width; TAG_W = ADDR_W - IDX_W (26 at defaults)
// - DATA_W  8   data word width; one word per line
// - LINES   8   number of lines; power of two, >= 2; IDX_W = $clog2(LINES)
// - CNT_W   16  width of hit/miss counters
// PORTS
// - clk          in   1       clock; all state updates on the falling edge
// - reset        in   1       asynchronous, active-high; clears all state
// - flush        in   1       invalidate all lines; sampled only in IDLE
// - req_valid    in   1       CPU request present
// - req_ready    out  1       (state==IDLE && !flush && !reset)
// - req_write    in   1       1 = store, 0 = load
// - req_addr     in   ADDR_W  word address; idx = [IDX_W-1:0], tag = [ADDR_W-1:IDX_W]
// - req_wdata    in   DATA_W  store data
// - resp_valid   out  1       one-cycle pulse, request complete; no backpressure
// - resp_hit     out  1       lookup result of the completed request
// - resp_rdata   out  DATA_W  load data; 0 for stores
// - mem_rd_valid out  1       line fetch request, held until mem_rd_ack
// - mem_rd_addr  out  ADDR_W  fetch address
// - mem_rd_ack   in   1       fetch done; mem_rd_data valid this cycle
// - mem_rd_data  in   DATA_W  fetched word
// - mem_wr_valid out  1       write-through request, held until mem_wr_ack
// - mem_wr_addr  out  ADDR_W  write address
// - mem_wr_data  out  DATA_W  write data
// - mem_wr_ack   in   1       write accepted
// - hit_count    out  CNT_W   saturating hit count
// - miss_count   out  CNT_W   saturating miss count
// BEHAVIOUR
// - Reset: state=IDLE, every valid/tag/data bit 0, counters 0, request regs 0; all outputs 0 incl. req_ready.
// - States: IDLE, CHECK, FILL, WRITE, RESP.
// - IDLE: flush=1 -> all valid bits cleared at the edge, stay IDLE, no request accepted (flush wins over request);
//   else req_valid&&req_ready -> latch write/addr/wdata, go CHECK.
// - CHECK: hit = valid[idx] && tag[idx]==tag. Hit -> hit_count+1, else miss_count+1 (saturate at all-ones).
//   read hit -> RESP (rdata = data[idx]); read miss -> FILL; write (hit or miss) -> WRITE.
// - FILL: mem_rd_valid=1, mem_rd_addr=latched addr; on mem_rd_ack: data[idx]=mem_rd_data, tag[idx]=tag,
//   valid[idx]=1, rdata=mem_rd_data, go RESP. Ack in the first FILL cycle is legal.
// - WRITE: mem_wr_valid=1 with latched addr/data; on mem_wr_ack: if hit, data[idx]=wdata; miss: no allocate,
//   arrays untouched; go RESP.
// - RESP: resp_valid=1 for exactly one cycle with resp_hit/resp_rdata; next state IDLE.
// - Latency (edges after acceptance to resp_valid): read hit 2; read miss 2+ack wait; store 2+ack wait.
// - flush outside IDLE is ignored; caller holds it until req_ready returns.
// - resp_hit/resp_rdata are meaningful only while resp_valid=1.
// - Reset mid-operation: state/arrays clear immediately; mem_*_valid drop asynchronously;
//   no partial line write; an ack arriving in IDLE is ignored.
// - Only one request in flight; req_ready=0 in every state but IDLE.
// TESTING
// - Reset, read 0x0000005 -> miss, mem_rd_addr=0x0000005; ack data 0xA5 -> resp_valid, resp_hit=0, rdata=0xA5, miss_count=1.
// - Re-read 0x0000005 -> resp_valid 2 edges after acceptance, hit=1, rdata=0xA5, no mem_rd_valid, hit_count=1.
// - Read 0x000000D (same idx 5, new tag) with ack 0x3C -> miss, line replaced; read 0x0000005 misses again.
// - Store 0x77 to 0x000000D (hit) -> mem_wr_valid until ack, then load returns 0x77 as hit;
//   store to 0x0000002 (miss) -> next load of 0x0000002 misses.
// - flush=1 with req_valid=1 in IDLE -> req_ready=0, request not taken; all lines then miss; counters unchanged.
// - reset during FILL before ack -> mem_rd_valid=0 at once; late ack ignored; all counters 0, next read misses.
// - CNT_W=2 build: 5 hits -> hit_count saturates at 3.

Source files
------------

// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache with
// flush-all and saturating hit/miss counters. State advances on falling clk.
// Revision: 1.0
// ============================================================================
module dm_cache_ctrl #(
  parameter int ADDR_W = 29,
  parameter int DATA_W = 8,
  parameter int LINES  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic              resp_hit_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              mem_rd_valid_o,
  output logic [ADDR_W-1:0] mem_rd_addr_o,
  input  logic              mem_rd_ack_i,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic              mem_wr_valid_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  input  logic              mem_wr_ack_i,
  output logic [CNT_W-1:0]  hit_count_o,
  output logic [CNT_W-1:0]  miss_count_o
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_FILL  = 3'd2,
    S_WRITE = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  state_e              state_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                hit_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                resp_valid_q;
  logic                mem_rd_valid_q;
  logic                mem_wr_valid_q;
  logic [CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]    miss_cnt_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                lookup_hit;

  assign idx        = addr_q[IDX_W-1:0];
  assign tag        = addr_q[ADDR_W-1:IDX_W];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      write_q        <= 1'b0;
      addr_q         <= '0;
      wdata_q        <= '0;
      hit_q          <= 1'b0;
      rdata_q        <= '0;
      resp_valid_q   <= 1'b0;
      mem_rd_valid_q <= 1'b0;
      mem_wr_valid_q <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      valid_q        <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // Flush takes priority; a concurrent request waits for ready.
          if (flush_i) begin
            valid_q <= '0;
          end else if (req_valid_i) begin
            write_q <= req_write_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          hit_q <= lookup_hit;
          if (lookup_hit) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
          end
          if (write_q) begin
            rdata_q        <= '0;
            mem_wr_valid_q <= 1'b1;
            state_q        <= S_WRITE;
          end else if (lookup_hit) begin
            rdata_q      <= data_q[idx];
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            mem_rd_valid_q <= 1'b1;
            state_q        <= S_FILL;
          end
        end
        S_FILL: begin
          if (mem_rd_ack_i) begin
            data_q[idx]    <= mem_rd_data_i;
            tag_q[idx]     <= tag;
            valid_q[idx]   <= 1'b1;
            rdata_q        <= mem_rd_data_i;
            mem_rd_valid_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_WRITE: begin
          // No write-allocate: a store miss leaves the arrays untouched.
          if (mem_wr_ack_i) begin
            if (hit_q) data_q[idx] <= wdata_q;
            mem_wr_valid_q <= 1'b0;
            resp_valid_q   <= 1'b1;
            state_q        <= S_RESP;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          resp_valid_q   <= 1'b0;
          mem_rd_valid_q <= 1'b0;
          mem_wr_valid_q <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o    = (state_q == S_IDLE) && !flush_i && !reset_i;
  assign resp_valid_o   = resp_valid_q;
  assign resp_hit_o     = hit_q;
  assign resp_rdata_o   = rdata_q;
  assign mem_rd_valid_o = mem_rd_valid_q;
  assign mem_rd_addr_o  = addr_q;
  assign mem_wr_valid_o = mem_wr_valid_q;
  assign mem_wr_addr_o  = addr_q;
  assign mem_wr_data_o  = wdata_q;
  assign hit_count_o    = hit_cnt_q;
  assign miss_count_o   = miss_cnt_q;

endmodule
`default_nettype wire
